// File: rtl/song_selector.sv
// Song selector: debounces next/prev/confirm buttons and drives the selected song number.
// Build option: define SONG_SEL_WRAP_EN to wrap at the ends of the range instead of saturating.
module song_selector #(
   parameter int unsigned NUM_SONGS       = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 200000,
   parameter logic [2:0]  SEL_MODE        = 3'b010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] mode,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_confirm,
   output logic [3:0] num,
   output logic       play_start,
   output logic       locked
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] NUM_MAX = 4'(NUM_SONGS);

   localparam int unsigned BTN_NEXT    = 0;
   localparam int unsigned BTN_PREV    = 1;
   localparam int unsigned BTN_CONFIRM = 2;

   typedef enum logic [1:0] {
      StIdle,
      StBrowse,
      StLocked
   } state_e;

   logic [2:0] btn_raw;
   logic [2:0] press;

   assign btn_raw = {btn_confirm, btn_prev, btn_next};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             stable_prev_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
         end else begin
            sync1_q <= btn_raw[i];
            sync2_q <= sync1_q;
            // Any return to the accepted level restarts the stability window.
            if (sync2_q == stable_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_q <= sync2_q;
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
         end
      end

      assign press[i] = press_q;
   end

   state_e     state_q, state_d;
   logic [3:0] num_q, num_d;
   logic       play_start_q, play_start_d;
   logic       locked_q;
   logic [3:0] num_inc, num_dec;
   logic       sel_active;

   assign sel_active = (mode == SEL_MODE);

   // Bounds are tested before the step, so 4-bit arithmetic never overflows.
`ifdef SONG_SEL_WRAP_EN
   assign num_inc = (num_q >= NUM_MAX) ? 4'd1 : num_q + 4'd1;
   assign num_dec = (num_q <= 4'd1) ? NUM_MAX : num_q - 4'd1;
`else
   assign num_inc = (num_q >= NUM_MAX) ? NUM_MAX : num_q + 4'd1;
   assign num_dec = (num_q <= 4'd1) ? 4'd1 : num_q - 4'd1;
`endif

   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      play_start_d = 1'b0;
      if (!sel_active) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StBrowse;
            end
            StBrowse: begin
               if (press[BTN_CONFIRM]) begin
                  state_d      = StLocked;
                  play_start_d = 1'b1;
               end else if (press[BTN_NEXT] && !press[BTN_PREV]) begin
                  num_d = num_inc;
               end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
                  num_d = num_dec;
               end
            end
            StLocked: begin
               if (press[BTN_CONFIRM]) begin
                  state_d = StBrowse;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         num_q        <= 4'd1;
         play_start_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         play_start_q <= play_start_d;
         locked_q     <= (state_d == StLocked);
      end
   end

   assign num        = num_q;
   assign play_start = play_start_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_song_selector.sv
// Directed self-checking bench for song_selector with DEBOUNCE_CYCLES=4, NUM_SONGS=3.
// Expectations follow SONG_SEL_WRAP_EN when the bench is built with it defined.
module tb_song_selector;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] mode = 3'b000;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       btn_confirm = 1'b0;
   logic [3:0] num;
   logic       play_start;
   logic       locked;

   int n_cmp = 0;
   int n_err = 0;
   int ps_count = 0;
   int ps_base;

   localparam logic [2:0] SEL = 3'b010;
`ifdef SONG_SEL_WRAP_EN
   localparam logic [3:0] EXP_TOP_NEXT = 4'd1;
   localparam logic [3:0] EXP_BOT_PREV = 4'd3;
`else
   localparam logic [3:0] EXP_TOP_NEXT = 4'd3;
   localparam logic [3:0] EXP_BOT_PREV = 4'd1;
`endif

   song_selector #(
      .NUM_SONGS      (3),
      .DEBOUNCE_CYCLES(4),
      .SEL_MODE       (3'b010)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .btn_next   (btn_next),
      .btn_prev   (btn_prev),
      .btn_confirm(btn_confirm),
      .num        (num),
      .play_start (play_start),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (play_start === 1'b1) ps_count++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btns(input logic [2:0] b);
      {btn_confirm, btn_prev, btn_next} = b;
   endtask

   // Press long enough for the event to land, then release and let the release settle.
   task automatic press(input logic [2:0] b);
      set_btns(b);
      tick(12);
      set_btns(3'b000);
      tick(8);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      mode  = 3'b000;
      set_btns(3'b000);
      tick(2);
      reset = 1'b0;
   endtask

   task automatic enter_sel;
      mode = SEL;
      tick(2);
   endtask

   task automatic test_reset;
      do_reset();
      tick(1);
      n_cmp++;
      if (num !== 4'd1) begin n_err++; $display("FAIL reset_num: got %0d want 1", num); end
      n_cmp++;
      if (play_start !== 1'b0) begin
         n_err++; $display("FAIL reset_play_start: got %b want 0", play_start);
      end
      n_cmp++;
      if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
   endtask

   task automatic test_next_press;
      enter_sel();
      btn_next = 1'b1;
      tick(7);
      n_cmp++;
      if (num !== 4'd1) begin n_err++; $display("FAIL next_before_edge8: got %0d want 1", num); end
      tick(1);
      n_cmp++;
      if (num !== 4'd2) begin n_err++; $display("FAIL next_at_edge8: got %0d want 2", num); end
      tick(12);
      btn_next = 1'b0;
      tick(10);
      n_cmp++;
      if (num !== 4'd2) begin n_err++; $display("FAIL next_single_step: got %0d want 2", num); end
   endtask

   task automatic test_glitch;
      do_reset();
      enter_sel();
      for (int i = 0; i < 3; i++) begin
         btn_next = 1'b1;
         tick(2);
         btn_next = 1'b0;
         tick(3);
      end
      tick(10);
      n_cmp++;
      if (num !== 4'd1) begin n_err++; $display("FAIL glitch_ignored: got %0d want 1", num); end
   endtask

   task automatic test_limits;
      do_reset();
      enter_sel();
      press(3'b001);
      press(3'b001);
      n_cmp++;
      if (num !== 4'd3) begin n_err++; $display("FAIL climb_to_top: got %0d want 3", num); end
      press(3'b001);
      n_cmp++;
      if (num !== EXP_TOP_NEXT) begin
         n_err++; $display("FAIL next_at_top: got %0d want %0d", num, EXP_TOP_NEXT);
      end
      do_reset();
      enter_sel();
      press(3'b010);
      n_cmp++;
      if (num !== EXP_BOT_PREV) begin
         n_err++; $display("FAIL prev_at_bottom: got %0d want %0d", num, EXP_BOT_PREV);
      end
   endtask

   task automatic test_confirm;
      do_reset();
      enter_sel();
      press(3'b001);
      ps_base = ps_count;
      btn_confirm = 1'b1;
      tick(7);
      n_cmp++;
      if (play_start !== 1'b0 || locked !== 1'b0) begin
         n_err++; $display("FAIL confirm_early: got ps=%b lk=%b want 0 0", play_start, locked);
      end
      tick(1);
      n_cmp++;
      if (play_start !== 1'b1 || locked !== 1'b1) begin
         n_err++; $display("FAIL confirm_lock: got ps=%b lk=%b want 1 1", play_start, locked);
      end
      tick(1);
      n_cmp++;
      if (play_start !== 1'b0 || locked !== 1'b1) begin
         n_err++; $display("FAIL confirm_one_cycle: got ps=%b lk=%b want 0 1", play_start, locked);
      end
      tick(10);
      btn_confirm = 1'b0;
      tick(8);
      n_cmp++;
      if (ps_count - ps_base !== 1) begin
         n_err++; $display("FAIL confirm_pulse_count: got %0d want 1", ps_count - ps_base);
      end
      press(3'b001);
      n_cmp++;
      if (num !== 4'd2 || locked !== 1'b1) begin
         n_err++; $display("FAIL locked_ignores_next: got num=%0d lk=%b want 2 1", num, locked);
      end
      ps_base = ps_count;
      press(3'b100);
      n_cmp++;
      if (locked !== 1'b0 || ps_count != ps_base) begin
         n_err++;
         $display("FAIL unlock: got lk=%b pulses=%0d want 0 0", locked, ps_count - ps_base);
      end
   endtask

   task automatic test_mode_exit;
      press(3'b100);
      mode = 3'b000;
      tick(1);
      n_cmp++;
      if (locked !== 1'b0) begin n_err++; $display("FAIL mode_exit_unlock: got %b want 0", locked); end
      press(3'b001);
      n_cmp++;
      if (num !== 4'd2 || locked !== 1'b0) begin
         n_err++; $display("FAIL idle_holds: got num=%0d lk=%b want 2 0", num, locked);
      end
      enter_sel();
      press(3'b001);
      n_cmp++;
      if (num !== 4'd3) begin n_err++; $display("FAIL reenter_browse: got %0d want 3", num); end
   endtask

   task automatic test_simultaneous;
      press(3'b010);
      press(3'b011);
      n_cmp++;
      if (num !== 4'd2) begin n_err++; $display("FAIL next_prev_same: got %0d want 2", num); end
      ps_base = ps_count;
      press(3'b101);
      n_cmp++;
      if (num !== 4'd2 || locked !== 1'b1 || ps_count - ps_base !== 1) begin
         n_err++;
         $display("FAIL confirm_wins: got num=%0d lk=%b pulses=%0d want 2 1 1",
                  num, locked, ps_count - ps_base);
      end
      press(3'b100);
   endtask

   task automatic test_mode_drop;
      btn_next = 1'b1;
      tick(7);
      mode = 3'b000;
      tick(1);
      n_cmp++;
      if (num !== 4'd2) begin n_err++; $display("FAIL mode_drop_press: got %0d want 2", num); end
      tick(4);
      btn_next = 1'b0;
      tick(8);
      enter_sel();
      n_cmp++;
      if (num !== 4'd2 || locked !== 1'b0) begin
         n_err++; $display("FAIL mode_drop_after: got num=%0d lk=%b want 2 0", num, locked);
      end
   endtask

   task automatic test_reset_locked;
      btn_confirm = 1'b1;
      tick(8);
      n_cmp++;
      if (locked !== 1'b1) begin n_err++; $display("FAIL pre_reset_lock: got %b want 1", locked); end
      reset = 1'b1;
      tick(1);
      n_cmp++;
      if (num !== 4'd1 || locked !== 1'b0 || play_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_lock: got num=%0d lk=%b ps=%b want 1 0 0", num, locked, play_start);
      end
      reset = 1'b0;
      tick(7);
      n_cmp++;
      if (play_start !== 1'b0) begin
         n_err++; $display("FAIL held_after_reset_early: got %b want 0", play_start);
      end
      tick(1);
      n_cmp++;
      if (play_start !== 1'b1 || locked !== 1'b1) begin
         n_err++;
         $display("FAIL held_after_reset_pulse: got ps=%b lk=%b want 1 1", play_start, locked);
      end
      btn_confirm = 1'b0;
      tick(8);
   endtask

   initial begin
      test_reset();
      test_next_press();
      test_glitch();
      test_limits();
      test_confirm();
      test_mode_exit();
      test_simultaneous();
      test_mode_drop();
      test_reset_locked();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/song_selector.md
# song_selector

Upstream controller for the song-number seven-segment display stage. Debounces the next/previous/confirm push buttons, maintains the current song number in the range 1..NUM_SONGS, and drives that number to the display stage. It also issues a one-cycle start pulse to the player when a song is confirmed. Selection is only active while the system mode equals the select mode (3'b010); in all other modes the block is idle and holds its number.

## Interface
- NUM_SONGS, 3, number of selectable songs; legal range 1..15
- DEBOUNCE_CYCLES, 200000, cycles a synchronized button level must stay stable before it is accepted; minimum 2
- SEL_MODE, 3'b010, mode value that enables selection

- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mode  input  3  system mode from the top-level controller
- btn_next  input  1  raw, asynchronous push button: next song
- btn_prev  input  1  raw, asynchronous push button: previous song
- btn_confirm  input  1  raw, asynchronous push button: confirm or unlock
- num  output  4  current song number, feeds the display stage `num`
- play_start  output  1  one-cycle pulse when a song is confirmed
- locked  output  1  high while the selection is confirmed (LOCKED state)

## Operation
- Per button:
  - 2-flop synchronizer, then a debounce counter, then a stable register, then a registered rising-edge press pulse.
  - The counter clears whenever the synchronized value equals the stable value.
  - Otherwise the counter increments. At DEBOUNCE_CYCLES-1 the stable register takes the synchronized value and the counter clears.
  - A press pulse fires only on a stable 0→1 transition. Release produces no event. Holding a button gives exactly one pulse.
- FSM states: IDLE, BROWSE, LOCKED. Reset state is IDLE.
  - Any state, mode != SEL_MODE: go to IDLE. This check has priority over all button events.
  - IDLE, mode == SEL_MODE: go to BROWSE.
  - BROWSE:
    - next pulse: num advances by one.
    - prev pulse: num goes back by one.
    - confirm pulse: go to LOCKED and assert play_start for one cycle.
  - LOCKED: next and prev are ignored. A confirm pulse returns to BROWSE with no play_start.
- Simultaneous events in BROWSE:
  - next and prev in the same cycle: both are ignored.
  - confirm together with next and/or prev: confirm wins, num is unchanged.
- num is held in IDLE and is not reset on mode change. Only reset returns it to 1.
- num always lies in 1..NUM_SONGS. Arithmetic is 4-bit unsigned, and the bound is checked before the update, so there is no 4-bit overflow.
- Press pulses that arrive in IDLE are discarded, not queued.

## Timing
- Reset values: num=1, play_start=0, locked=0, state IDLE. All debounce counters are 0, and all synchronizer and stable registers are 0.
- Button latency: raw input rises and is held from cycle 0.
  - Synchronized value high after edge 2.
  - Stable register high at edge DEBOUNCE_CYCLES+2.
  - Press pulse high during the cycle after edge DEBOUNCE_CYCLES+3.
  - num or state updates at edge DEBOUNCE_CYCLES+4.
- play_start is registered. It is high for exactly the one cycle following the BROWSE→LOCKED transition edge; it asserts together with locked.
- locked is a registered decode of the LOCKED state.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no pulse and leave the counter cleared.
- Reset asserted mid-debounce or in LOCKED:
  - all state returns to the reset values on the next edge;
  - a button still held after reset produces a fresh pulse after the full latency.
- Mode leaving SEL_MODE in the same cycle as a press pulse: the state goes to IDLE and the press is dropped.

## Configuration
- SONG_SEL_WRAP_EN defined:
  - next at NUM_SONGS goes to 1;
  - prev at 1 goes to NUM_SONGS.
- SONG_SEL_WRAP_EN undefined:
  - next at NUM_SONGS saturates at NUM_SONGS;
  - prev at 1 saturates at 1;
  - no pulse or flag is produced at the limit.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_SONGS=3.
- Reset then mode=3'b010, one clean btn_next press held 20 cycles -> num goes 1→2 at edge 8 after the press, and exactly one step occurs.
- btn_next pulses high for 2 cycles, three times -> no press event, num stays 1.
- In BROWSE with num=3, press next -> num=1 with SONG_SEL_WRAP_EN, num=3 without. From num=1, press prev -> num=3 with the macro, num=1 without.
- Press confirm at num=2 -> play_start high for exactly 1 cycle, locked=1. Then press next -> num stays 2. Press confirm -> locked=0 with no play_start.
- Set mode=3'b000 while locked, then press next -> state IDLE, locked=0, num holds 2. Return to mode 3'b010 -> BROWSE with num=2.
- btn_next and btn_prev become stable on the same edge -> num unchanged. Assert reset while locked and btn_confirm is held -> num=1 and locked=0 next cycle; one new play_start arrives after the full latency.
